// File: rtl/slurm32_cpu_pkg.sv
// Shared slurm32 CPU definitions: load/store size encodings, memory-stage
// state encodings and the alignment rule.
package slurm32_cpu_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE  = 2'd0,
      SIZE_HALF  = 2'd1,
      SIZE_WORD  = 2'd2,
      SIZE_DWORD = 2'd3
   } ls_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2
   } mem_state_e;

   // A dword access on a 32-bit datapath is treated as misaligned.
   function automatic logic is_misaligned(input ls_size_e   size,
                                          input logic [2:0] addr_lo,
                                          input logic       has_dword);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = |addr_lo[1:0];
         default:   bad = !has_dword || (|addr_lo);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/slurm32_load_extend.sv
// Selects the addressed lane of a read word and zero/sign-extends it to the
// full datapath width. Purely combinational.
module slurm32_load_extend
   import slurm32_cpu_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0]            rdata,
   input  logic [$clog2(BITS/8)-1:0]  lane_off,
   input  ls_size_e                   size,
   input  logic                       sign_ext,
   output logic [BITS-1:0]            data
);

   logic [BITS-1:0] shifted;

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      shifted = rdata >> {lane_off, 3'b000};
      data    = shifted;
      case (size)
         SIZE_BYTE: data = sign_ext ? BITS'($signed(shifted[7:0]))  : BITS'(shifted[7:0]);
         SIZE_HALF: data = sign_ext ? BITS'($signed(shifted[15:0])) : BITS'(shifted[15:0]);
         SIZE_WORD: data = sign_ext ? BITS'($signed(shifted[31:0])) : BITS'(shifted[31:0]);
         default:   data = shifted;
      endcase
   end

endmodule

// File: rtl/slurm32_cpu_execute_mem.sv
// Execute-stage load/store unit: computes the effective address, issues one
// bus request per access, and writes back extended load data.
module slurm32_cpu_execute_mem
   import slurm32_cpu_pkg::*;
#(
   parameter int BITS          = 32,
   parameter int ADDRESS_BITS  = 32,
   parameter int IMM_BITS      = 24,
   parameter int REGISTER_BITS = 4
) (
   input  logic                                        CLK,
   input  logic                                        RSTb,
   input  logic                                        ls_valid,
   input  logic                                        ls_is_store,
   input  logic [1:0]                                  ls_size,
   input  logic                                        ls_signed,
   input  logic [REGISTER_BITS-1:0]                    ls_dest,
   input  logic [BITS-1:0]                             regA,
   input  logic [BITS-1:0]                             regB,
   input  logic [IMM_BITS-1:0]                         imm_reg,
   output logic                                        bus_valid,
   input  logic                                        bus_ready,
   output logic                                        bus_write,
   output logic [ADDRESS_BITS-$clog2(BITS/8)-1:0]      bus_address,
   output logic [BITS-1:0]                             bus_wdata,
   output logic [BITS/8-1:0]                           bus_mask,
   input  logic                                        bus_rvalid,
   input  logic [BITS-1:0]                             bus_rdata,
   output logic                                        stall,
   output logic                                        wb_valid,
   output logic [REGISTER_BITS-1:0]                    wb_reg,
   output logic [BITS-1:0]                             wb_data,
   output logic                                        align_fault
);

   localparam int LANES    = BITS / 8;
   localparam int OFF_BITS = $clog2(LANES);
   localparam int WADDR_W  = ADDRESS_BITS - OFF_BITS;

   mem_state_e               state_q, state_d;
   logic                     bus_valid_q, bus_valid_d;
   logic                     write_q, write_d;
   logic [WADDR_W-1:0]       addr_q, addr_d;
   logic [OFF_BITS-1:0]      off_q, off_d;
   logic [LANES-1:0]         mask_q, mask_d;
   logic [BITS-1:0]          wdata_q, wdata_d;
   ls_size_e                 size_q, size_d;
   logic                     signed_q, signed_d;
   logic [REGISTER_BITS-1:0] dest_q, dest_d;
   logic                     wb_valid_q, wb_valid_d;
   logic [REGISTER_BITS-1:0] wb_reg_q, wb_reg_d;
   logic [BITS-1:0]          wb_data_q, wb_data_d;
   logic                     align_fault_q, align_fault_d;

   ls_size_e                 req_size;
   logic [ADDRESS_BITS-1:0]  eff_addr;
   logic                     misaligned;
   logic [LANES-1:0]         mask_base;
   logic [BITS-1:0]          lane_data;
   logic [BITS-1:0]          load_data;

   assign req_size   = ls_size_e'(ls_size);
   assign eff_addr   = ADDRESS_BITS'(regA) + ADDRESS_BITS'(imm_reg);
   assign misaligned = is_misaligned(req_size, eff_addr[2:0], BITS == 64);

   // Stall is combinational so the upstream stage freezes in the acceptance cycle.
   assign stall = (state_q != ST_IDLE) || (ls_valid && !misaligned);

   slurm32_load_extend #(.BITS(BITS)) u_load_extend (
      .rdata    (bus_rdata),
      .lane_off (off_q),
      .size     (size_q),
      .sign_ext (signed_q),
      .data     (load_data)
   );

   always_comb begin
      mask_base = '1;
      lane_data = regB;
      case (req_size)
         SIZE_BYTE: begin
            mask_base = LANES'(1);
            lane_data = {LANES{regB[7:0]}};
         end
         SIZE_HALF: begin
            mask_base = LANES'(3);
            lane_data = {(LANES/2){regB[15:0]}};
         end
         SIZE_WORD: begin
            mask_base = LANES'(15);
            lane_data = {(LANES/4){regB[31:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      bus_valid_d   = bus_valid_q;
      write_d       = write_q;
      addr_d        = addr_q;
      off_d         = off_q;
      mask_d        = mask_q;
      wdata_d       = wdata_q;
      size_d        = size_q;
      signed_d      = signed_q;
      dest_d        = dest_q;
      wb_valid_d    = 1'b0;
      wb_reg_d      = wb_reg_q;
      wb_data_d     = wb_data_q;
      align_fault_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ls_valid && misaligned) begin
               align_fault_d = 1'b1;
            end else if (ls_valid) begin
               state_d     = ST_REQ;
               bus_valid_d = 1'b1;
               write_d     = ls_is_store;
               addr_d      = eff_addr[ADDRESS_BITS-1:OFF_BITS];
               off_d       = eff_addr[OFF_BITS-1:0];
               mask_d      = mask_base << eff_addr[OFF_BITS-1:0];
               wdata_d     = lane_data;
               size_d      = req_size;
               signed_d    = ls_signed;
               dest_d      = ls_dest;
            end
         end
         ST_REQ: begin
            // Read data arriving alongside bus_ready is not ours yet and is dropped.
            if (bus_ready) begin
               bus_valid_d = 1'b0;
               state_d     = write_q ? ST_IDLE : ST_WAIT_R;
            end
         end
         ST_WAIT_R: begin
            if (bus_rvalid) begin
               wb_valid_d = 1'b1;
               wb_reg_d   = dest_q;
               wb_data_d  = load_data;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state_q       <= ST_IDLE;
         bus_valid_q   <= 1'b0;
         write_q       <= 1'b0;
         addr_q        <= '0;
         off_q         <= '0;
         mask_q        <= '0;
         wdata_q       <= '0;
         size_q        <= SIZE_BYTE;
         signed_q      <= 1'b0;
         dest_q        <= '0;
         wb_valid_q    <= 1'b0;
         wb_reg_q      <= '0;
         wb_data_q     <= '0;
         align_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bus_valid_q   <= bus_valid_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         off_q         <= off_d;
         mask_q        <= mask_d;
         wdata_q       <= wdata_d;
         size_q        <= size_d;
         signed_q      <= signed_d;
         dest_q        <= dest_d;
         wb_valid_q    <= wb_valid_d;
         wb_reg_q      <= wb_reg_d;
         wb_data_q     <= wb_data_d;
         align_fault_q <= align_fault_d;
      end
   end

   assign bus_valid   = bus_valid_q;
   assign bus_write   = write_q;
   assign bus_address = addr_q;
   assign bus_mask    = mask_q;
   assign bus_wdata   = wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_reg      = wb_reg_q;
   assign wb_data     = wb_data_q;
   assign align_fault = align_fault_q;

endmodule

// File: tb/tb_slurm32_cpu_execute_mem.sv
// Bench for slurm32_cpu_execute_mem: directed and random load/store traffic on
// a 32-bit instance checked against a byte-level model, plus a 64-bit instance.
module tb_slurm32_cpu_execute_mem;

   logic        CLK;
   logic        RSTb;

   // 32-bit instance
   logic        ls_valid, ls_is_store, ls_signed;
   logic [1:0]  ls_size;
   logic [3:0]  ls_dest;
   logic [31:0] regA, regB;
   logic [23:0] imm_reg;
   logic        bus_valid, bus_ready, bus_write, bus_rvalid;
   logic [29:0] bus_address;
   logic [31:0] bus_wdata, bus_rdata;
   logic [3:0]  bus_mask;
   logic        stall, wb_valid, align_fault;
   logic [3:0]  wb_reg;
   logic [31:0] wb_data;

   // 64-bit instance
   logic        ls_valid_w, ls_is_store_w, ls_signed_w;
   logic [1:0]  ls_size_w;
   logic [3:0]  ls_dest_w;
   logic [63:0] regA_w, regB_w;
   logic [23:0] imm_reg_w;
   logic        bus_valid_w, bus_ready_w, bus_write_w, bus_rvalid_w;
   logic [28:0] bus_address_w;
   logic [63:0] bus_wdata_w, bus_rdata_w;
   logic [7:0]  bus_mask_w;
   logic        stall_w, wb_valid_w, align_fault_w;
   logic [3:0]  wb_reg_w;
   logic [63:0] wb_data_w;

   int errors = 0;
   int checks = 0;

   slurm32_cpu_execute_mem dut (
      .CLK(CLK), .RSTb(RSTb),
      .ls_valid(ls_valid), .ls_is_store(ls_is_store), .ls_size(ls_size),
      .ls_signed(ls_signed), .ls_dest(ls_dest), .regA(regA), .regB(regB),
      .imm_reg(imm_reg), .bus_valid(bus_valid), .bus_ready(bus_ready),
      .bus_write(bus_write), .bus_address(bus_address), .bus_wdata(bus_wdata),
      .bus_mask(bus_mask), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .align_fault(align_fault)
   );

   slurm32_cpu_execute_mem #(.BITS(64)) dut_w (
      .CLK(CLK), .RSTb(RSTb),
      .ls_valid(ls_valid_w), .ls_is_store(ls_is_store_w), .ls_size(ls_size_w),
      .ls_signed(ls_signed_w), .ls_dest(ls_dest_w), .regA(regA_w), .regB(regB_w),
      .imm_reg(imm_reg_w), .bus_valid(bus_valid_w), .bus_ready(bus_ready_w),
      .bus_write(bus_write_w), .bus_address(bus_address_w), .bus_wdata(bus_wdata_w),
      .bus_mask(bus_mask_w), .bus_rvalid(bus_rvalid_w), .bus_rdata(bus_rdata_w),
      .stall(stall_w), .wb_valid(wb_valid_w), .wb_reg(wb_reg_w), .wb_data(wb_data_w),
      .align_fault(align_fault_w)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // ---------------- reference model (32-bit datapath) ----------------
   function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [23:0] im);
      return a + {8'h00, im};
   endfunction

   function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] addr);
      int nbytes = 1 << sz;
      if (sz == 2'd3) return 1'b1;
      return (addr % nbytes) != 0;
   endfunction

   function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [31:0] addr);
      int nbytes = 1 << sz;
      int m = ((1 << nbytes) - 1) << (addr % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] b);
      logic [31:0] w;
      int nbytes = 1 << sz;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % nbytes) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
      logic [63:0] v;
      logic [63:0] keep;
      int nbits = 8 << sz;
      v    = {32'h0, rd} >> (8 * (addr % 4));
      keep = (64'd1 << nbits) - 64'd1;
      v    = v & keep;
      if (sgn && v[nbits-1]) v = v | ~keep;
      return v[31:0];
   endfunction

   // One complete access on the 32-bit instance, checked cycle by cycle.
   task automatic do_txn(input string tag, input bit st, input logic [1:0] sz, input bit sgn,
                         input logic [3:0] dst, input logic [31:0] a, input logic [31:0] b,
                         input logic [23:0] im, input logic [31:0] rd,
                         input int rdly, input int vdly);
      logic [31:0] addr = m_addr(a, im);
      bit          mis  = m_misaligned(sz, addr);
      logic [31:0] ld   = m_load(sz, sgn, addr, rd);

      @(negedge CLK);
      ls_valid = 1'b1; ls_is_store = st; ls_size = sz; ls_signed = sgn;
      ls_dest = dst; regA = a; regB = b; imm_reg = im;
      #1 check({tag, ".stall_accept"}, stall, !mis);
      @(negedge CLK);
      ls_valid = 1'b0;
      #1;
      if (mis) begin
         check({tag, ".align_fault"}, align_fault, 1'b1);
         check({tag, ".no_bus_on_fault"}, bus_valid, 1'b0);
         check({tag, ".no_stall_on_fault"}, stall, 1'b0);
         @(negedge CLK);
         #1 check({tag, ".fault_pulse_end"}, align_fault, 1'b0);
         check({tag, ".still_idle"}, bus_valid, 1'b0);
         return;
      end
      check({tag, ".no_fault"}, align_fault, 1'b0);
      for (int c = 0; c <= rdly; c++) begin
         check({tag, ".bus_valid"}, bus_valid, 1'b1);
         check({tag, ".bus_write"}, bus_write, st);
         check({tag, ".bus_address"}, bus_address, addr[31:2]);
         check({tag, ".bus_mask"}, bus_mask, m_mask(sz, addr));
         if (st) check({tag, ".bus_wdata"}, bus_wdata, m_wdata(sz, b));
         check({tag, ".stall_busy"}, stall, 1'b1);
         if (c < rdly) begin
            // upstream noise while busy must be ignored
            ls_valid = 1'b1; regA = $urandom; regB = $urandom; ls_size = 2'($urandom);
            @(negedge CLK);
            ls_valid = 1'b0;
            #1;
         end
      end
      bus_ready = 1'b1;
      if (!st) begin
         bus_rvalid = 1'b1;
         bus_rdata  = ~rd;
      end
      @(negedge CLK);
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      #1 check({tag, ".bus_valid_drop"}, bus_valid, 1'b0);
      if (st) begin
         check({tag, ".store_done_stall"}, stall, 1'b0);
         return;
      end
      check({tag, ".no_early_wb"}, wb_valid, 1'b0);
      check({tag, ".stall_wait"}, stall, 1'b1);
      for (int c = 0; c < vdly; c++) begin
         @(negedge CLK);
         #1 check({tag, ".wb_idle_wait"}, wb_valid, 1'b0);
      end
      bus_rvalid = 1'b1; bus_rdata = rd;
      @(negedge CLK);
      bus_rvalid = 1'b0; bus_rdata = $urandom;
      #1 check({tag, ".wb_valid"}, wb_valid, 1'b1);
      check({tag, ".wb_data"}, wb_data, ld);
      check({tag, ".wb_reg"}, wb_reg, dst);
      check({tag, ".stall_after_load"}, stall, 1'b0);
      @(negedge CLK);
      #1 check({tag, ".wb_pulse_end"}, wb_valid, 1'b0);
   endtask

   // A load on the 64-bit instance with hand-derived expectations.
   task automatic load64(input string tag, input logic [1:0] sz, input bit sgn,
                         input logic [63:0] a, input logic [63:0] rd,
                         input logic [28:0] exp_addr, input logic [7:0] exp_mask,
                         input logic [63:0] exp_data);
      @(negedge CLK);
      ls_valid_w = 1'b1; ls_is_store_w = 1'b0; ls_size_w = sz; ls_signed_w = sgn;
      ls_dest_w = 4'd9; regA_w = a; imm_reg_w = 24'd0;
      #1 check({tag, ".stall"}, stall_w, 1'b1);
      @(negedge CLK);
      ls_valid_w = 1'b0;
      #1 check({tag, ".bus_valid"}, bus_valid_w, 1'b1);
      check({tag, ".bus_address"}, bus_address_w, exp_addr);
      check({tag, ".bus_mask"}, bus_mask_w, exp_mask);
      bus_ready_w = 1'b1;
      @(negedge CLK);
      bus_ready_w = 1'b0; bus_rvalid_w = 1'b1; bus_rdata_w = rd;
      @(negedge CLK);
      bus_rvalid_w = 1'b0;
      #1 check({tag, ".wb_valid"}, wb_valid_w, 1'b1);
      check({tag, ".wb_data"}, wb_data_w, exp_data);
      check({tag, ".wb_reg"}, wb_reg_w, 4'd9);
   endtask

   initial begin
      RSTb = 1'b0;
      ls_valid = 0; ls_is_store = 0; ls_size = 0; ls_signed = 0; ls_dest = 0;
      regA = 0; regB = 0; imm_reg = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
      ls_valid_w = 0; ls_is_store_w = 0; ls_size_w = 0; ls_signed_w = 0; ls_dest_w = 0;
      regA_w = 0; regB_w = 0; imm_reg_w = 0; bus_ready_w = 0; bus_rvalid_w = 0; bus_rdata_w = 0;
      repeat (2) @(negedge CLK);
      #1;
      check("rst.bus_valid", bus_valid, 1'b0);
      check("rst.wb_valid", wb_valid, 1'b0);
      check("rst.align_fault", align_fault, 1'b0);
      check("rst.stall", stall, 1'b0);
      check("rst.bus_address", bus_address, 30'h0);
      check("rst.bus_mask", bus_mask, 4'h0);
      check("rst.bus_wdata", bus_wdata, 32'h0);
      check("rst.wb_data", wb_data, 32'h0);
      RSTb = 1'b1;

      // byte store at 0x1003: word 0x400, lane 3, replicated data
      do_txn("byte_store", 1'b1, 2'd0, 1'b0, 4'd0, 32'h1001, 32'h0000_00AB, 24'd2, 32'h0, 0, 0);
      // signed half load at 0x2002 picks the upper half 0x8001
      do_txn("half_load", 1'b0, 2'd1, 1'b1, 4'd7, 32'h2000, 32'h0, 24'd2, 32'h8001_1234, 0, 0);
      do_txn("word_misaligned", 1'b0, 2'd2, 1'b0, 4'd1, 32'h3, 32'h0, 24'd0, 32'h0, 0, 0);
      do_txn("dword_on_32", 1'b0, 2'd3, 1'b0, 4'd1, 32'h8, 32'h0, 24'd0, 32'h0, 0, 0);
      do_txn("ready_held_low", 1'b1, 2'd1, 1'b0, 4'd0, 32'h4000, 32'hCAFE_BEEF, 24'd6, 32'h0, 5, 0);
      do_txn("addr_wrap", 1'b0, 2'd0, 1'b0, 4'd3, 32'hFFFF_FFFF, 32'h0, 24'd2, 32'h1122_3344, 1, 2);

      // reset while waiting for read data abandons the load
      @(negedge CLK);
      ls_valid = 1'b1; ls_is_store = 1'b0; ls_size = 2'd2; ls_signed = 1'b0;
      ls_dest = 4'd5; regA = 32'h100; imm_reg = 24'd0;
      @(negedge CLK);
      ls_valid = 1'b0; bus_ready = 1'b1;
      @(negedge CLK);
      bus_ready = 1'b0; RSTb = 1'b0;
      #1 check("rst_wait.stall_before", stall, 1'b1);
      @(negedge CLK);
      RSTb = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
      #1 check("rst_wait.idle_stall", stall, 1'b0);
      @(negedge CLK);
      bus_rvalid = 1'b0;
      #1 check("rst_wait.no_wb", wb_valid, 1'b0);
      check("rst_wait.no_bus", bus_valid, 1'b0);
      check("rst_wait.wb_data", wb_data, 32'h0);

      for (int n = 0; n < 40; n++) begin
         logic [1:0]  sz  = 2'($urandom_range(0, 3));
         logic [31:0] a   = $urandom;
         // bias half the accesses towards naturally aligned addresses
         if (n % 2 == 0) a = a & ~32'h7;
         do_txn("random", 1'($urandom), sz, 1'($urandom), 4'($urandom), a, $urandom,
                24'($urandom) & 24'hFFFFF8, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      load64("dword64", 2'd3, 1'b0, 64'h8, 64'hDEAD_BEEF_0123_4567,
             29'h1, 8'hFF, 64'hDEAD_BEEF_0123_4567);
      load64("sword64", 2'd2, 1'b1, 64'hC, 64'h8000_0000_1234_5678,
             29'h1, 8'hF0, 64'hFFFF_FFFF_8000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
